// File: rtl/ball_bus_if.sv
// Register-bus bundle carrying ball position writes to the display peripheral.
interface ball_bus_if;
  logic       chipselect;
  logic       write;
  logic [2:0] address;
  logic [7:0] writedata;

  modport master (output chipselect, output write, output address, output writedata);
  modport slave  (input  chipselect, input  write, input  address, input  writedata);
endinterface

// File: rtl/ball_mover.sv
// Bouncing-ball position engine: advances one step per VGA frame and pushes the
// new 10.6 fixed-point coordinates to the display peripheral as four byte writes.
module ball_mover #(
  parameter int XMAX   = 639,
  parameter int YMAX   = 479,
  parameter int RADIUS = 16,
  parameter int VX0    = 64,
  parameter int VY0    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        vs_n,
  ball_bus_if.master  bus,
  output logic [15:0] x_pos,
  output logic [15:0] y_pos
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UPDATE = 3'd1;
  localparam logic [2:0] WR_XH  = 3'd2;
  localparam logic [2:0] WR_XL  = 3'd3;
  localparam logic [2:0] WR_YH  = 3'd4;
  localparam logic [2:0] WR_YL  = 3'd5;

  localparam logic signed [17:0] X_LO = 18'(RADIUS << 6);
  localparam logic signed [17:0] X_HI = 18'((XMAX - RADIUS) << 6);
  localparam logic signed [17:0] Y_LO = 18'(RADIUS << 6);
  localparam logic signed [17:0] Y_HI = 18'((YMAX - RADIUS) << 6);

  logic [2:0]         state_reg, state_next;
  logic               vs_reg;
  logic               tick;
  logic [15:0]        x_reg, y_reg, x_next, y_next;
  logic signed [16:0] vx_reg, vy_reg, vx_next, vy_next;

  // One axis step: clamp to the wall and force the velocity to point back inward.
  function automatic void step_axis(
    input  logic [15:0]        pos,
    input  logic signed [16:0] vel,
    input  logic signed [17:0] lo,
    input  logic signed [17:0] hi,
    output logic [15:0]        pos_n,
    output logic signed [16:0] vel_n
  );
    logic signed [17:0] nxt;
    logic signed [16:0] mag;
    nxt = $signed({2'b00, pos}) + $signed({vel[16], vel});
    mag = vel[16] ? -vel : vel;
    if (nxt > hi) begin
      pos_n = hi[15:0];
      vel_n = -mag;
    end else if (nxt < lo) begin
      pos_n = lo[15:0];
      vel_n = mag;
    end else begin
      pos_n = nxt[15:0];
      vel_n = vel;
    end
  endfunction

  assign tick = vs_reg & ~vs_n;

  always_comb begin
    x_next  = x_reg;
    y_next  = y_reg;
    vx_next = vx_reg;
    vy_next = vy_reg;
    step_axis(x_reg, vx_reg, X_LO, X_HI, x_next, vx_next);
    step_axis(y_reg, vy_reg, Y_LO, Y_HI, y_next, vy_next);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tick && enable) state_next = UPDATE;
      UPDATE:  state_next = WR_XH;
      WR_XH:   state_next = WR_XL;
      WR_XL:   state_next = WR_YH;
      WR_YH:   state_next = WR_YL;
      WR_YL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      vs_reg    <= 1'b1;
      x_reg     <= 16'h5000;
      y_reg     <= 16'h3C00;
      vx_reg    <= 17'(VX0);
      vy_reg    <= 17'(VY0);
    end else begin
      state_reg <= state_next;
      vs_reg    <= vs_n;
      if (state_reg == UPDATE) begin
        x_reg  <= x_next;
        y_reg  <= y_next;
        vx_reg <= vx_next;
        vy_reg <= vy_next;
      end
    end
  end

  // Bus outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 8'h00;
    case (state_reg)
      WR_XH: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd4;
        bus.writedata  = x_reg[15:8];
      end
      WR_XL: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd5;
        bus.writedata  = x_reg[7:0];
      end
      WR_YH: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd6;
        bus.writedata  = y_reg[15:8];
      end
      WR_YL: begin
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd7;
        bus.writedata  = y_reg[7:0];
      end
      default: ;
    endcase
  end

  assign x_pos = x_reg;
  assign y_pos = y_reg;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: a default instance plus a fast instance whose
// large velocities make both axes hit the far walls on the very first frame.
module tb_ball_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        vs_n = 1'b1;
  logic [15:0] x1, y1, x2, y2;

  ball_bus_if bus1();
  ball_bus_if bus2();

  ball_mover dut (
    .clk(clk), .reset(reset), .enable(enable), .vs_n(vs_n),
    .bus(bus1), .x_pos(x1), .y_pos(y1)
  );

  ball_mover #(.XMAX(639), .YMAX(477), .RADIUS(16), .VX0(20000), .VY0(15000)) dut_fast (
    .clk(clk), .reset(reset), .enable(enable), .vs_n(vs_n),
    .bus(bus2), .x_pos(x2), .y_pos(y2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         wr_cnt, w2_cnt;
  logic [2:0] wr_addr [16];
  logic [7:0] wr_data [16];
  int         wr_idx  [16];
  logic [2:0] w2_addr [16];
  logic [7:0] w2_data [16];
  int         w2_idx  [16];

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    vs_n  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Falling vs_n at sample 0, then record every bus write on samples 1..10.
  task automatic do_frame(input int second_at, input int drop_en_at);
    wr_cnt = 0;
    w2_cnt = 0;
    @(negedge clk);
    vs_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus1.write && wr_cnt < 16) begin
        wr_addr[wr_cnt] = bus1.address;
        wr_data[wr_cnt] = bus1.writedata;
        wr_idx[wr_cnt]  = i;
        wr_cnt++;
      end
      if (bus2.write && w2_cnt < 16) begin
        w2_addr[w2_cnt] = bus2.address;
        w2_data[w2_cnt] = bus2.writedata;
        w2_idx[w2_cnt]  = i;
        w2_cnt++;
      end
      if (i == 1) vs_n = 1'b1;
      if (i == second_at) vs_n = 1'b0;
      if (i == second_at + 1) vs_n = 1'b1;
      if (i == drop_en_at) enable = 1'b0;
    end
  endtask

  task automatic fast_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      vs_n = 1'b0;
      @(negedge clk);
      vs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (x1 !== 16'h5000 || y1 !== 16'h3C00) begin
      errors++;
      $display("FAIL reset_pos got x=%h y=%h want x=5000 y=3c00", x1, y1);
    end
    checks++;
    if ({bus1.chipselect, bus1.write, bus1.address, bus1.writedata} !== 13'd0) begin
      errors++;
      $display("FAIL reset_bus got cs=%b wr=%b a=%0d d=%h want all zero",
               bus1.chipselect, bus1.write, bus1.address, bus1.writedata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ed [4];
    ed = '{8'h50, 8'h40, 8'h3C, 8'h20};
    apply_reset();
    enable = 1'b1;
    do_frame(-1, -1);
    checks++;
    if (wr_cnt !== 4) begin
      errors++;
      $display("FAIL basic_count got %0d want 4", wr_cnt);
    end
    for (int i = 0; i < 4 && i < wr_cnt; i++) begin
      checks++;
      if (wr_idx[i] !== i + 2 || wr_addr[i] !== 3'(4 + i) || wr_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d got cyc %0d a=%0d d=%h want cyc %0d a=%0d d=%h",
                 i, wr_idx[i], wr_addr[i], wr_data[i], i + 2, 4 + i, ed[i]);
      end
    end
    checks++;
    if (x1 !== 16'h5040 || y1 !== 16'h3C20) begin
      errors++;
      $display("FAIL basic_pos got x=%h y=%h want x=5040 y=3c20", x1, y1);
    end
  endtask

  task automatic test_disabled();
    apply_reset();
    enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      do_frame(-1, -1);
      checks++;
      if (wr_cnt !== 0 || x1 !== 16'h5000 || y1 !== 16'h3C00) begin
        errors++;
        $display("FAIL disabled_frame%0d got writes=%0d x=%h y=%h want writes=0 x=5000 y=3c00",
                 f, wr_cnt, x1, y1);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_bounce();
    logic [7:0] ed [4];
    logic [15:0] ex [3];
    logic [15:0] ey [3];
    ex = '{16'h9BC0, 16'h9BC0, 16'h9B80};
    ey = '{16'h61E0, 16'h6200, 16'h6220};
    apply_reset();
    enable = 1'b1;
    fast_ticks(302);
    checks++;
    if (x1 !== 16'h9B80 || y1 !== 16'h61C0) begin
      errors++;
      $display("FAIL bounce_approach got x=%h y=%h want x=9b80 y=61c0", x1, y1);
    end
    for (int f = 0; f < 3; f++) begin
      ed = '{ex[f][15:8], ex[f][7:0], ey[f][15:8], ey[f][7:0]};
      do_frame(-1, -1);
      checks++;
      if (wr_cnt !== 4 || x1 !== ex[f] || y1 !== ey[f]) begin
        errors++;
        $display("FAIL bounce_frame%0d got writes=%0d x=%h y=%h want writes=4 x=%h y=%h",
                 f, wr_cnt, x1, y1, ex[f], ey[f]);
      end
      for (int i = 0; i < 4 && i < wr_cnt; i++) begin
        checks++;
        if (wr_addr[i] !== 3'(4 + i) || wr_data[i] !== ed[i]) begin
          errors++;
          $display("FAIL bounce_write%0d_%0d got a=%0d d=%h want a=%0d d=%h",
                   f, i, wr_addr[i], wr_data[i], 4 + i, ed[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    enable = 1'b1;
    do_frame(3, -1);
    checks++;
    if (wr_cnt !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", wr_cnt);
    end
    checks++;
    if (x1 !== 16'h5040 || y1 !== 16'h3C20) begin
      errors++;
      $display("FAIL b2b_pos got x=%h y=%h want x=5040 y=3c20", x1, y1);
    end
  endtask

  task automatic test_enable_change();
    apply_reset();
    enable = 1'b1;
    do_frame(-1, 3);
    checks++;
    if (wr_cnt !== 4 || x1 !== 16'h5040) begin
      errors++;
      $display("FAIL enable_drop got writes=%0d x=%h want writes=4 x=5040", wr_cnt, x1);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int stray;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    vs_n = 1'b0;
    @(negedge clk);
    vs_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus1.write !== 1'b1 || bus1.address !== 3'd5) begin
      errors++;
      $display("FAIL midrst_wrxl got wr=%b a=%0d want wr=1 a=5", bus1.write, bus1.address);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus1.chipselect, bus1.write, bus1.address, bus1.writedata} !== 13'd0 || x1 !== 16'h5000) begin
      errors++;
      $display("FAIL midrst_async got cs=%b wr=%b a=%0d d=%h x=%h want zero bus x=5000",
               bus1.chipselect, bus1.write, bus1.address, bus1.writedata, x1);
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus1.write || bus1.chipselect) stray++;
    end
    checks++;
    if (stray !== 0 || x1 !== 16'h5000) begin
      errors++;
      $display("FAIL midrst_after got stray=%0d x=%h want stray=0 x=5000", stray, x1);
    end
  endtask

  task automatic test_corner();
    logic [7:0] ed [4];
    ed = '{8'h9B, 8'hC0, 8'h73, 8'h40};
    apply_reset();
    enable = 1'b1;
    do_frame(-1, -1);
    checks++;
    if (w2_cnt !== 4 || x2 !== 16'h9BC0 || y2 !== 16'h7340) begin
      errors++;
      $display("FAIL corner_clamp got writes=%0d x=%h y=%h want writes=4 x=9bc0 y=7340",
               w2_cnt, x2, y2);
    end
    for (int i = 0; i < 4 && i < w2_cnt; i++) begin
      checks++;
      if (w2_idx[i] !== i + 2 || w2_addr[i] !== 3'(4 + i) || w2_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL corner_write%0d got cyc %0d a=%0d d=%h want cyc %0d a=%0d d=%h",
                 i, w2_idx[i], w2_addr[i], w2_data[i], i + 2, 4 + i, ed[i]);
      end
    end
    do_frame(-1, -1);
    checks++;
    if (x2 !== 16'h4DA0 || y2 !== 16'h38A8) begin
      errors++;
      $display("FAIL corner_reverse got x=%h y=%h want x=4da0 y=38a8", x2, y2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_bounce();
    test_back_to_back();
    test_enable_change();
    test_reset_mid();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
